osc_freq_meter: RTL and testbench

- Multi-channel ring-oscillator frequency meter for the entropy/side-channel path.
- Each channel owns one `osc` cell (ports `reset`, `out`). The oscillator output is synchronised into the CLK domain and its rising edges are counted over a programmable window of CLK cycles.
- Results are latched for the host as a parallel count vector. The block supports single-shot and continuous modes, per-channel saturation flags and a deterministic test-input mux for verification.

---
 rtl/osc_freq_meter.sv | 162 ++++++++++++++++
 tb/tb_osc_freq_meter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_freq_meter.sv
// Multi-channel ring-oscillator frequency meter: counts synchronised oscillator
// rising edges over a programmable window of CLK cycles and latches the results.

// Behavioural stand-in for the ring-oscillator hard macro; output rests low in reset.
module osc (
    input  logic reset,
    output logic out
);
    assign out = ~reset;
endmodule

module osc_freq_meter #(
    parameter int CHANNELS     = 4,
    parameter int COUNT_WIDTH  = 32,
    parameter int WINDOW_WIDTH = 24
) (
    input  logic                            CLK,
    input  logic                            RESET_N,
    input  logic                            START,
    input  logic                            CONTINUOUS,
    input  logic [WINDOW_WIDTH-1:0]         WINDOW,
    input  logic [CHANNELS-1:0]             OSC_EN,
    input  logic                            TEST_MODE,
    input  logic [CHANNELS-1:0]             TEST_OSC,
    output logic                            BUSY,
    output logic                            VALID,
    output logic [CHANNELS*COUNT_WIDTH-1:0] COUNT,
    output logic [CHANNELS-1:0]             SATURATED
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_LATCH   = 2'd3;

    localparam logic [COUNT_WIDTH-1:0]  CNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0]  CNT_ONE = 1;
    localparam logic [WINDOW_WIDTH-1:0] WIN_ONE = 1;

    logic [CHANNELS-1:0] osc_reset;
    logic [CHANNELS-1:0] osc_out;
    logic [CHANNELS-1:0] src;

    assign osc_reset = {CHANNELS{~RESET_N | TEST_MODE}} | ~OSC_EN;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_osc
        osc u_osc (
            .reset (osc_reset[g]),
            .out   (osc_out[g])
        );
    end

    assign src = TEST_MODE ? TEST_OSC : osc_out;

    logic [CHANNELS-1:0] s1_q, s1_d;
    logic [CHANNELS-1:0] s2_q, s2_d;
    logic [CHANNELS-1:0] s3_q, s3_d;
    logic [CHANNELS-1:0] rise;

    logic [1:0]                              state_q, state_d;
    logic [WINDOW_WIDTH-1:0]                 win_len_q, win_len_d;
    logic [WINDOW_WIDTH-1:0]                 win_cnt_q, win_cnt_d;
    logic [CHANNELS-1:0][COUNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [CHANNELS-1:0]                     sat_q, sat_d;
    logic                                    busy_q, busy_d;
    logic                                    valid_q, valid_d;
    logic [CHANNELS*COUNT_WIDTH-1:0]         count_q, count_d;
    logic [CHANNELS-1:0]                     sat_out_q, sat_out_d;

    always_comb begin
        s1_d = src;
        s2_d = s1_q;
        s3_d = s2_q;
        rise = s2_q & ~s3_q;

        state_d   = state_q;
        win_len_d = win_len_q;
        win_cnt_d = win_cnt_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        count_d   = count_q;
        sat_out_d = sat_out_q;
        valid_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d   = ST_ARM;
                    win_len_d = (WINDOW == '0) ? WIN_ONE : WINDOW;
                end
            end
            ST_ARM: begin
                cnt_d     = '0;
                sat_d     = '0;
                win_cnt_d = win_len_q;
                state_d   = ST_MEASURE;
            end
            ST_MEASURE: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (rise[i]) begin
                        if (cnt_q[i] == CNT_MAX) begin
                            sat_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_ONE;
                        end
                    end
                end
                win_cnt_d = win_cnt_q - WIN_ONE;
                // Results are published on the final counting edge so VALID and COUNT coincide in LATCH.
                if (win_cnt_q == WIN_ONE) begin
                    state_d   = ST_LATCH;
                    valid_d   = 1'b1;
                    count_d   = cnt_d;
                    sat_out_d = sat_d;
                end
            end
            ST_LATCH: begin
                state_d = CONTINUOUS ? ST_ARM : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            state_q   <= ST_IDLE;
            win_len_q <= '0;
            win_cnt_q <= '0;
            cnt_q     <= '0;
            sat_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            count_q   <= '0;
            sat_out_q <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            state_q   <= state_d;
            win_len_q <= win_len_d;
            win_cnt_q <= win_cnt_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
            sat_out_q <= sat_out_d;
        end
    end

    assign BUSY      = busy_q;
    assign VALID     = valid_q;
    assign COUNT     = count_q;
    assign SATURATED = sat_out_q;

endmodule

// File: tb/tb_osc_freq_meter.sv
// Randomised scoreboard bench for osc_freq_meter: a cycle-stamped source history
// yields expected counts per window; a monitor compares whenever VALID is due.

module tb_osc_freq_meter;
    localparam int CH   = 4;
    localparam int CW   = 32;
    localparam int CWS  = 4;
    localparam int WW   = 24;
    localparam int HMAX = 8192;

    logic              CLK = 1'b0;
    logic              RESET_N;
    logic              START;
    logic              CONTINUOUS;
    logic [WW-1:0]     WINDOW;
    logic [CH-1:0]     OSC_EN;
    logic              TEST_MODE;
    logic [CH-1:0]     TEST_OSC;
    logic              BUSY, VALID, BUSY_S, VALID_S;
    logic [CH*CW-1:0]  COUNT;
    logic [CH*CWS-1:0] COUNT_S;
    logic [CH-1:0]     SATURATED, SATURATED_S;

    always #5 CLK = ~CLK;

    osc_freq_meter #(.CHANNELS(CH), .COUNT_WIDTH(CW), .WINDOW_WIDTH(WW)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .CONTINUOUS(CONTINUOUS),
        .WINDOW(WINDOW), .OSC_EN(OSC_EN), .TEST_MODE(TEST_MODE), .TEST_OSC(TEST_OSC),
        .BUSY(BUSY), .VALID(VALID), .COUNT(COUNT), .SATURATED(SATURATED)
    );

    osc_freq_meter #(.CHANNELS(CH), .COUNT_WIDTH(CWS), .WINDOW_WIDTH(WW)) dut_s (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .CONTINUOUS(CONTINUOUS),
        .WINDOW(WINDOW), .OSC_EN(OSC_EN), .TEST_MODE(TEST_MODE), .TEST_OSC(TEST_OSC),
        .BUSY(BUSY_S), .VALID(VALID_S), .COUNT(COUNT_S), .SATURATED(SATURATED_S)
    );

    typedef struct {
        int                cyc;
        logic [CH*CW-1:0]  cnt;
        logic [CH-1:0]     sat;
        logic [CH*CWS-1:0] cnt_s;
        logic [CH-1:0]     sat_s;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   ph0   = 0;
    int   half [CH];
    logic [CH-1:0] hist [HMAX];

    bit   m_active = 1'b0;
    bit   m_busy   = 1'b0;
    bit   m_was;
    int   m_ws, m_wl, m_end;
    logic [CH-1:0] m_v;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected result for the window covering source cycles m_ws .. m_ws+m_wl-1.
    task automatic push_expect();
        exp_t e;
        int   n;
        int   smax;
        smax    = (1 << CWS) - 1;
        e.cyc   = m_end;
        e.cnt   = '0;
        e.sat   = '0;
        e.cnt_s = '0;
        e.sat_s = '0;
        for (int ch = 0; ch < CH; ch++) begin
            n = 0;
            for (int c = m_ws; c < m_ws + m_wl; c++) begin
                if (c > 0 && c < HMAX && hist[c][ch] && !hist[c-1][ch]) n++;
            end
            e.cnt[ch*CW +: CW]    = n[CW-1:0];
            e.cnt_s[ch*CWS +: CWS] = (n > smax) ? smax[CWS-1:0] : n[CWS-1:0];
            e.sat_s[ch]           = (n > smax);
        end
        sb.push_back(e);
    endtask

    // Reference model: inputs of cycle cyc are seen at the edge that ends it.
    always @(posedge CLK) begin
        m_v = TEST_MODE ? TEST_OSC : '0;
        if (cyc < HMAX) hist[cyc] = m_v;
        if (!RESET_N) begin
            m_active = 1'b0;
            m_busy   = 1'b0;
            sb.delete();
        end else begin
            m_was = m_active;
            if (m_was && cyc == m_end) begin
                if (CONTINUOUS) begin
                    m_ws  = cyc;
                    m_end = cyc + m_wl + 2;
                end else begin
                    m_active = 1'b0;
                end
            end else if (!m_was && START) begin
                m_active = 1'b1;
                m_ws     = cyc;
                m_wl     = (WINDOW == '0) ? 1 : int'(WINDOW);
                m_end    = cyc + m_wl + 2;
            end
            if (m_active && cyc == m_ws + m_wl - 1) push_expect();
            m_busy = m_active;
        end
        cyc++;
    end

    logic [CH*CW-1:0]  last_cnt   = '0;
    logic [CH-1:0]     last_sat   = '0;
    logic [CH*CWS-1:0] last_cnt_s = '0;
    logic [CH-1:0]     last_sat_s = '0;
    exp_t              mon_e;
    bit                exp_valid;

    always @(negedge CLK) begin
        if (!RESET_N) begin
            check("rst_busy",  128'(BUSY),      128'(0));
            check("rst_valid", 128'(VALID),     128'(0));
            check("rst_count", 128'(COUNT),     128'(0));
            check("rst_sat",   128'(SATURATED), 128'(0));
            check("rst_count_s", 128'(COUNT_S), 128'(0));
            last_cnt   = '0;
            last_sat   = '0;
            last_cnt_s = '0;
            last_sat_s = '0;
        end else begin
            while (sb.size() > 0 && sb[0].cyc < cyc) void'(sb.pop_front());
            exp_valid = (sb.size() > 0 && sb[0].cyc == cyc);
            check("busy",    128'(BUSY),    128'(m_busy));
            check("busy_s",  128'(BUSY_S),  128'(m_busy));
            check("valid",   128'(VALID),   128'(exp_valid));
            check("valid_s", 128'(VALID_S), 128'(exp_valid));
            if (exp_valid) begin
                mon_e = sb.pop_front();
                last_cnt   = mon_e.cnt;
                last_sat   = mon_e.sat;
                last_cnt_s = mon_e.cnt_s;
                last_sat_s = mon_e.sat_s;
            end
            check("count",   128'(COUNT),       128'(last_cnt));
            check("sat",     128'(SATURATED),   128'(last_sat));
            check("count_s", 128'(COUNT_S),     128'(last_cnt_s));
            check("sat_s",   128'(SATURATED_S), 128'(last_sat_s));
        end
    end

    task automatic drive_osc();
        for (int ch = 0; ch < CH; ch++) begin
            if (half[ch] > 0)       TEST_OSC[ch] = (((cyc - ph0) / half[ch]) % 2) == 1;
            else if (half[ch] < 0)  TEST_OSC[ch] = 1'($urandom_range(0, 1));
            else                    TEST_OSC[ch] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        drive_osc();
    endtask

    task automatic set_half(input int a, input int b, input int c, input int d);
        half[0] = a;
        half[1] = b;
        half[2] = c;
        half[3] = d;
        ph0 = cyc;
    endtask

    task automatic pulse_start(input int w);
        WINDOW = WW'(w);
        START  = 1'b1;
        tick();
        START  = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((m_active || sb.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: window still open after %0d cycles", bound);
        end
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N    = 1'b0;
        START      = 1'b0;
        CONTINUOUS = 1'b0;
        TEST_MODE  = 1'b1;
        WINDOW     = '0;
        OSC_EN     = '1;
        TEST_OSC   = '0;
        set_half(0, 0, 0, 0);
        repeat (3) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        repeat (3) tick();

        // Fixed-period sources, nominal window.
        set_half(2, 5, 0, 0);
        pulse_start(100);
        wait_idle(200);

        // Zero-length window behaves as a single cycle.
        for (int k = 0; k < 3; k++) begin
            pulse_start(0);
            wait_idle(20);
        end

        // Saturation on the narrow-counter instance.
        set_half(1, 0, 3, 0);
        pulse_start(40);
        wait_idle(100);

        // Continuous mode, dropped mid-window.
        set_half(2, 0, 0, 7);
        CONTINUOUS = 1'b1;
        pulse_start(20);
        repeat (98) tick();
        CONTINUOUS = 1'b0;
        wait_idle(100);

        // START pulses while busy are ignored.
        set_half(2, 5, 1, 3);
        pulse_start(30);
        repeat (5) tick();
        for (int k = 0; k < 12; k++) begin
            START = 1'($urandom_range(0, 1));
            tick();
        end
        START = 1'b0;
        wait_idle(100);

        // Random sources, windows, restarts and continuous mode.
        for (int r = 0; r < 8; r++) begin
            set_half(-1, -1, -1, (r % 2 == 1) ? 3 : -1);
            CONTINUOUS = 1'($urandom_range(0, 1));
            pulse_start($urandom_range(0, 25));
            for (int k = 0; k < 40; k++) begin
                START  = ($urandom_range(0, 7) == 0);
                WINDOW = WW'($urandom_range(0, 25));
                tick();
            end
            START      = 1'b0;
            CONTINUOUS = 1'b0;
            wait_idle(100);
        end

        // Oscillators disabled and not in test mode: no edges.
        TEST_MODE = 1'b0;
        OSC_EN    = '0;
        set_half(-1, -1, -1, -1);
        pulse_start(15);
        wait_idle(50);
        set_half(0, 0, 0, 0);
        repeat (3) tick();
        TEST_MODE = 1'b1;
        OSC_EN    = '1;
        repeat (3) tick();

        // Asynchronous reset in the middle of a window.
        set_half(2, 5, 0, 0);
        pulse_start(100);
        repeat (44) tick();
        set_half(0, 0, 0, 0);
        repeat (5) tick();
        RESET_N = 1'b0;
        #1;
        check("arst_busy",    128'(BUSY),        128'(0));
        check("arst_valid",   128'(VALID),       128'(0));
        check("arst_count",   128'(COUNT),       128'(0));
        check("arst_sat",     128'(SATURATED),   128'(0));
        check("arst_busy_s",  128'(BUSY_S),      128'(0));
        check("arst_count_s", 128'(COUNT_S),     128'(0));
        check("arst_sat_s",   128'(SATURATED_S), 128'(0));
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        drive_osc();
        repeat (60) tick();
        set_half(2, 5, 0, 0);
        pulse_start(100);
        wait_idle(200);

        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
